// File: rtl/modexp_rl_param.sv
// rtl/modexp_rl_param.sv - right-to-left binary modular exponentiator
// One bit-serial Blakley multiplier is time-shared by base reduction, multiply and square steps.
module modexp_rl_param #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     r,
  output logic                 err
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_MUL_R, S_MUL_Y, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     base_q, base_d, mod_q, mod_d, acc_q, acc_d, y_q, y_d;
  logic [WIDTH-1:0]     p_q, p_d, r_q, r_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [WIDTH-1:0]     mul_a, mul_b, res;
  logic [WIDTH+1:0]     mod_x, step;
  logic [EXP_WIDTH-1:0] exp_sh;

  function automatic state_t scan(input logic [EXP_WIDTH-1:0] e);
    state_t s;
    if (e == '0)    s = S_DONE;
    else if (e[0])  s = S_MUL_R;
    else            s = S_MUL_Y;
    return s;
  endfunction

  // One Blakley step: P = 2P + a[i]*b, then at most two subtractions keep P < m.
  always_comb begin
    mul_a = base_q;
    mul_b = WIDTH'(1);
    case (state_q)
      S_MUL_R: begin mul_a = acc_q; mul_b = y_q; end
      S_MUL_Y: begin mul_a = y_q;   mul_b = y_q; end
      default: ;
    endcase
    mod_x = {2'b00, mod_q};
    step  = {1'b0, p_q, 1'b0} + (mul_a[bit_q] ? {2'b00, mul_b} : '0);
    if (step >= mod_x) step = step - mod_x;
    if (step >= mod_x) step = step - mod_x;
    res    = step[WIDTH-1:0];
    exp_sh = exp_q >> 1;
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    exp_d   = exp_q;
    mod_d   = mod_q;
    acc_d   = acc_q;
    y_d     = y_q;
    p_d     = p_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        // busy_q still high here means this is the done cycle; start is ignored.
        busy_d = 1'b0;
        if (start && !busy_q) begin
          base_d  = base;
          exp_d   = exp;
          mod_d   = modulus;
          acc_d   = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
          p_d     = '0;
          bit_d   = CW'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = (modulus == '0) ? S_DONE : S_REDUCE;
        end
      end
      S_REDUCE, S_MUL_R, S_MUL_Y: begin
        p_d   = res;
        bit_d = bit_q - CW'(1);
        if (bit_q == '0) begin
          p_d   = '0;
          bit_d = CW'(WIDTH - 1);
          case (state_q)
            S_REDUCE: begin
              y_d     = res;
              state_d = scan(exp_q);
            end
            S_MUL_R: begin
              acc_d   = res;
              state_d = (exp_sh == '0) ? S_DONE : S_MUL_Y;
            end
            default: begin
              y_d     = res;
              exp_d   = exp_sh;
              state_d = scan(exp_sh);
            end
          endcase
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        r_d     = (mod_q == '0) ? '0 : acc_q;
        err_d   = (mod_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      exp_q   <= '0;
      mod_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      p_q     <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      mod_q   <= mod_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      p_q     <= p_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r    = r_q;
  assign err  = err_q;
endmodule
